// File: rtl/channel_rx_pkg.sv
// Shared types and helpers for the channel receive path.
//   SAMPLE_W   : width of a channel sample
//   sample_t   : two's-complement channel sample
//   rx_state_t : receiver activity state (IDLE / INTEGRATE)
//   acc_width  : accumulator width that cannot wrap for spb samples
package channel_rx_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE,
    INTEGRATE
  } rx_state_t;

  function automatic int acc_width(input int spb);
    return SAMPLE_W + $clog2(spb);
  endfunction

endpackage

// File: rtl/rx_integrate_dump.sv
// Integrate-and-dump bit detector.
// Sums SAMPLES_PER_BIT accepted samples and makes a hard decision on the
// full sum (sum >= 0 -> 1).
//   clk, reset : rising-edge clock, synchronous active-high reset
//   sample     : signed channel sample
//   accept     : sample is taken this cycle
//   clear      : discard the partial bit (accumulator and sample count)
//   decide     : combinational; this accepted sample completes a bit
//   decision   : combinational; the bit value decided this cycle
//   bit_out    : registered last decided bit
//   bit_valid  : one-cycle pulse, one cycle after the completing sample
module rx_integrate_dump
  import channel_rx_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  sample_t sample,
  input  logic    accept,
  input  logic    clear,
  output logic    decide,
  output logic    decision,
  output logic    bit_out,
  output logic    bit_valid
);

  localparam int ACC_W = acc_width(SAMPLES_PER_BIT);
  localparam int CNT_W = $clog2(SAMPLES_PER_BIT);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic [CNT_W-1:0]        sample_cnt;

  always_comb begin
    sum      = acc + {{(ACC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    decide   = accept && (sample_cnt == CNT_W'(SAMPLES_PER_BIT-1));
    decision = ~sum[ACC_W-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      sample_cnt <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
    end else begin
      bit_valid <= decide;
      if (decide) begin
        bit_out <= decision;
      end
      if (clear || decide) begin
        acc        <= '0;
        sample_cnt <= '0;
      end else if (accept) begin
        acc        <= sum;
        sample_cnt <= sample_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/channel_receiver.sv
// Receive-side detector: integrate-and-dump bit decisions packed into
// WORD_BITS-wide words offered downstream through valid/ready.
//   CLOCK_50   : system clock
//   reset      : synchronous active-high reset
//   rx_sample  : signed channel sample, valid when sample_en
//   sample_en  : sample strobe
//   enable     : low ignores samples and holds all partial state
//   resync     : discard partial bit and word (outputs untouched)
//   bit_out    : last decided bit, bit_valid pulses when it updates
//   word_out   : packed word (zero above WORD_BITS-1), word_valid while
//                unconsumed, consumed on word_valid & word_ready
//   overflow   : sticky; a completed word was dropped
module channel_receiver
  import channel_rx_pkg::*;
#(
  parameter int SAMPLES_PER_BIT = 4,
  parameter int WORD_BITS       = 16,
  parameter int MSB_FIRST       = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [15:0] rx_sample,
  input  logic        sample_en,
  input  logic        enable,
  input  logic        resync,
  output logic        bit_out,
  output logic        bit_valid,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        overflow
);

  localparam int BCNT_W = $clog2(WORD_BITS);

  rx_state_t             state;
  logic                  accept;
  logic                  decide;
  logic                  decision;
  logic                  complete;
  logic [BCNT_W-1:0]     bit_cnt;
  logic [WORD_BITS-1:0]  shift_reg;
  logic [WORD_BITS-1:0]  packed_word;

  // Acceptance follows enable directly rather than the registered state so
  // the first strobe after re-enabling is not lost.
  assign accept = sample_en & enable & ~resync;

  rx_integrate_dump #(
    .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
  ) u_integrate (
    .clk      (CLOCK_50),
    .reset    (reset),
    .sample   (sample_t'(rx_sample)),
    .accept   (accept),
    .clear    (resync),
    .decide   (decide),
    .decision (decision),
    .bit_out  (bit_out),
    .bit_valid(bit_valid)
  );

  // Packing uses the combinational decision so a completed word appears in
  // the same cycle as the bit_valid of its last bit.
  always_comb begin
    if (MSB_FIRST != 0) begin
      packed_word = {shift_reg[WORD_BITS-2:0], decision};
    end else begin
      packed_word = {decision, shift_reg[WORD_BITS-1:1]};
    end
    complete = decide && (bit_cnt == BCNT_W'(WORD_BITS-1));
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE:      if (enable)  state <= INTEGRATE;
        INTEGRATE: if (!enable) state <= IDLE;
        default:   state <= IDLE;
      endcase

      if (resync) begin
        bit_cnt   <= '0;
        shift_reg <= '0;
      end else if (decide) begin
        shift_reg <= packed_word;
        bit_cnt   <= complete ? '0 : bit_cnt + BCNT_W'(1);
      end

      if (complete) begin
        if (!word_valid || word_ready) begin
          word_out   <= 16'(packed_word);
          word_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_channel_receiver.sv
module tb_channel_receiver;

  localparam int SPB = 4;
  localparam int WB  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rx_sample = '0;
  logic        sample_en = 1'b0;
  logic        enable = 1'b1;
  logic        resync = 1'b0;
  logic        word_ready = 1'b1;

  logic        bit_out, bit_valid, word_valid, overflow;
  logic [15:0] word_out;
  logic        bit_out_l, bit_valid_l, word_valid_l, overflow_l;
  logic [15:0] word_out_lsb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  channel_receiver #(.SAMPLES_PER_BIT(SPB), .WORD_BITS(WB), .MSB_FIRST(1)) dut (
    .CLOCK_50(clk), .reset(reset), .rx_sample(rx_sample), .sample_en(sample_en),
    .enable(enable), .resync(resync), .bit_out(bit_out), .bit_valid(bit_valid),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .overflow(overflow)
  );

  channel_receiver #(.SAMPLES_PER_BIT(SPB), .WORD_BITS(WB), .MSB_FIRST(0)) dut_lsb (
    .CLOCK_50(clk), .reset(reset), .rx_sample(rx_sample), .sample_en(sample_en),
    .enable(enable), .resync(resync), .bit_out(bit_out_l), .bit_valid(bit_valid_l),
    .word_out(word_out_lsb), .word_valid(word_valid_l), .word_ready(word_ready),
    .overflow(overflow_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer sums per bit, a queue of decided bits per word.
  bit   model_ok = 1'b0;
  int   m_sum = 0, m_n = 0;
  int   m_bits[$];
  logic m_bit = 1'b0, m_bv = 1'b0, m_wv = 1'b0, m_ovf = 1'b0;
  logic [15:0] m_word = '0, m_word_lsb = '0;

  always @(posedge clk) begin
    logic        done;
    logic [15:0] w_msb, w_lsb;
    if (reset) begin
      model_ok = 1'b1;
      m_sum = 0; m_n = 0; m_bits.delete();
      m_bit = 0; m_bv = 0; m_wv = 0; m_ovf = 0; m_word = '0; m_word_lsb = '0;
    end else begin
      done = 1'b0;
      w_msb = '0;
      w_lsb = '0;
      m_bv = 1'b0;
      if (resync) begin
        m_sum = 0; m_n = 0; m_bits.delete();
      end else if (sample_en && enable) begin
        m_sum = m_sum + int'($signed(rx_sample));
        m_n++;
        if (m_n == SPB) begin
          m_bit = (m_sum >= 0);
          m_bv  = 1'b1;
          m_sum = 0;
          m_n   = 0;
          m_bits.push_back(int'(m_bit));
          if (m_bits.size() == WB) begin
            for (int i = 0; i < WB; i++) begin
              if (m_bits[i] != 0) begin
                w_msb[WB-1-i] = 1'b1;
                w_lsb[i]      = 1'b1;
              end
            end
            m_bits.delete();
            done = 1'b1;
          end
        end
      end
      if (done) begin
        if (!m_wv || word_ready) begin
          m_word = w_msb; m_word_lsb = w_lsb; m_wv = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (m_wv && word_ready) begin
        m_wv = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("bit_out",      32'(bit_out),      32'(m_bit));
      check("bit_valid",    32'(bit_valid),    32'(m_bv));
      check("word_valid",   32'(word_valid),   32'(m_wv));
      check("word_out",     32'(word_out),     32'(m_word));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("word_out_lsb", 32'(word_out_lsb), 32'(m_word_lsb));
    end
  end

  // Snapshot of DUT outputs taken right after the edge that samples a strobe.
  logic        cap_bv, cap_wv;
  logic [15:0] cap_word, cap_lsb;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [15:0] s);
    rx_sample = s;
    sample_en = 1'b1;
    tick();
    cap_bv   = bit_valid;
    cap_wv   = word_valid;
    cap_word = word_out;
    cap_lsb  = word_out_lsb;
    sample_en = 1'b0;
    tick();
  endtask

  task automatic send_bit(input logic b);
    for (int i = 0; i < SPB; i++) strobe(b ? 16'h7FFF : 16'h8000);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < WB; i++) send_bit(w[WB-1-i]);
  endtask

  logic [15:0] mixed[4] = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h0001};

  initial begin
    tick(); tick(); tick();
    check("rst_bit_out", 32'(bit_out), 0);
    check("rst_bit_valid", 32'(bit_valid), 0);
    check("rst_word_out", 32'(word_out), 0);
    check("rst_word_valid", 32'(word_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    tick();

    // max positive: pulse only on 4th strobe
    for (int i = 0; i < 3; i++) strobe(16'h7FFF);
    check("pos_no_early_bv", 32'(cap_bv), 0);
    strobe(16'h7FFF);
    check("pos_bv", 32'(cap_bv), 1);
    check("pos_bit", 32'(bit_out), 1);
    check("pos_bv_one_cycle", 32'(bit_valid), 0);

    for (int i = 0; i < 4; i++) strobe(16'hFFFF);
    check("neg4_bit", 32'(bit_out), 0);
    for (int i = 0; i < 4; i++) strobe(mixed[i]);
    check("zero_sum_bit", 32'(bit_out), 1);
    for (int i = 0; i < 4; i++) strobe(16'h8000);
    check("min_no_wrap_bit", 32'(bit_out), 0);
    for (int i = 0; i < 4; i++) strobe(16'h7FFF);
    check("max_sum_bit", 32'(bit_out), 1);

    // realign before word tests
    resync = 1'b1; tick(); resync = 1'b0; tick();

    word_ready = 1'b1;
    send_word(16'hAAAA);
    check("alt_wv", 32'(cap_wv), 1);
    check("alt_word", 32'(cap_word), 32'h0000AAAA);
    check("alt_word_lsb", 32'(cap_lsb), 32'h00005555);
    check("alt_wv_one_cycle", 32'(word_valid), 0);

    word_ready = 1'b0;
    send_word(16'hAAAA);
    check("hold_first_word", 32'(word_out), 32'h0000AAAA);
    check("hold_no_ovf", 32'(overflow), 0);
    send_word(16'hFFFF);
    check("drop_word_kept", 32'(word_out), 32'h0000AAAA);
    check("drop_ovf", 32'(overflow), 1);
    check("drop_wv", 32'(word_valid), 1);
    word_ready = 1'b1;
    tick();
    check("accept_wv_clear", 32'(word_valid), 0);
    check("ovf_sticky", 32'(overflow), 1);

    // resync mid-bit, with a coincident strobe that must be discarded
    strobe(16'h7FFF); strobe(16'h7FFF);
    rx_sample = 16'h7FFF; sample_en = 1'b1; resync = 1'b1;
    tick();
    sample_en = 1'b0; resync = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) strobe(16'hFFFF);
    check("resync_no_early_bv", 32'(cap_bv), 0);
    strobe(16'hFFFF);
    check("resync_bv", 32'(cap_bv), 1);
    check("resync_bit", 32'(bit_out), 0);

    // enable low mid-bit
    strobe(16'h7FFF); strobe(16'h7FFF);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe(16'h8000);
      check("disabled_no_bv", 32'(cap_bv), 0);
    end
    enable = 1'b1;
    strobe(16'h7FFF);
    check("reenable_no_early_bv", 32'(cap_bv), 0);
    strobe(16'h7FFF);
    check("reenable_bv", 32'(cap_bv), 1);
    check("reenable_bit", 32'(bit_out), 1);

    // reset mid-word and mid-bit
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    strobe(16'h8000); strobe(16'h8000);
    reset = 1'b1;
    tick();
    check("midrst_bit_out", 32'(bit_out), 0);
    check("midrst_word_out", 32'(word_out), 0);
    check("midrst_word_valid", 32'(word_valid), 0);
    check("midrst_overflow", 32'(overflow), 0);
    reset = 1'b0;
    tick();
    send_word(16'h00FF);
    check("fresh_word", 32'(cap_word), 32'h000000FF);
    check("fresh_word_lsb", 32'(cap_lsb), 32'h0000FF00);
    check("fresh_wv", 32'(cap_wv), 1);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
